// File: rtl/safe_code_sequencer.sv
// Safe unlock sequencer: collects keypad digits, checks them against the
// stored code, drives the bolt and LEDs, and locks out after repeated failures.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | locked, waiting for the first digit
// ENTRY     | collecting code digits, idle timeout running
// CHECK     | one-cycle compare of entered digits against code_reg
// OPEN      | bolt released, auto-relock timer running
// SET_NEW   | bolt released, collecting a replacement code
// LOCKOUT   | too many failures, keys ignored until timer expires
module safe_code_sequencer #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAIL       = 3,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int UNLOCK_CYCLES  = 5000,
    parameter int LOCKOUT_CYCLES = 20000,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       lock,
    output logic       green,
    output logic       blue,
    output logic       lockout,
    output logic [2:0] fail_cnt
);

    localparam int W       = 4 * CODE_LEN;
    localparam int CW      = $clog2(CODE_LEN + 1);
    localparam int MAX_A   = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(CODE_LEN);
    localparam logic [2:0]    MAX_F    = 3'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_SET_NEW, S_LOCKOUT
    } state_t;

    typedef enum logic [1:0] {
        BUF_HOLD, BUF_CLEAR, BUF_LOAD, BUF_SHIFT
    } buf_op_t;

    state_t          state;
    state_t          state_nxt;
    buf_op_t         buf_op;
    logic            timer_clr;
    logic            code_wr;
    logic [2:0]      fail_nxt;
    logic [2:0]      fail_inc;
    logic [W-1:0]    code_reg;
    logic [W-1:0]    code_buf;
    logic [W+3:0]    buf_shifted;
    logic [CW-1:0]   dig_cnt;
    logic            overflow;
    logic [TW-1:0]   timer;
    logic            is_digit;
    logic            is_star;
    logic            is_hash;
    logic            entry_exp;
    logic            open_exp;
    logic            lock_exp;
    logic            full_ok;

    assign is_digit    = key_valid && (key_code <= 4'd9);
    assign is_star     = key_valid && (key_code == 4'hA);
    assign is_hash     = key_valid && (key_code == 4'hB);
    assign entry_exp   = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign open_exp    = (timer == TW'(UNLOCK_CYCLES - 1));
    assign lock_exp    = (timer == TW'(LOCKOUT_CYCLES - 1));
    assign full_ok     = (dig_cnt == FULL_CNT) && !overflow;
    assign buf_shifted = {code_buf, key_code};
    assign fail_inc    = (fail_cnt >= MAX_F) ? MAX_F : fail_cnt + 3'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath control; timer expiry takes priority over keys
    always_comb begin
        state_nxt = state;
        buf_op    = BUF_HOLD;
        timer_clr = 1'b0;
        code_wr   = 1'b0;
        fail_nxt  = fail_cnt;
        case (state)
            S_IDLE: begin
                if (is_digit) begin
                    state_nxt = S_ENTRY;
                    buf_op    = BUF_LOAD;
                end
            end
            S_ENTRY: begin
                if (entry_exp) begin
                    state_nxt = S_IDLE;
                    buf_op    = BUF_CLEAR;
                end else if (is_digit) begin
                    buf_op    = BUF_SHIFT;
                    timer_clr = 1'b1;
                end else if (is_star) begin
                    buf_op    = BUF_CLEAR;
                end else if (is_hash) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                buf_op = BUF_CLEAR;
                if (full_ok && (code_buf == code_reg)) begin
                    fail_nxt  = 3'd0;
                    state_nxt = S_OPEN;
                end else begin
                    fail_nxt  = fail_inc;
                    state_nxt = (fail_inc == MAX_F) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_OPEN: begin
                if (open_exp || is_hash) begin
                    state_nxt = S_IDLE;
                end else if (is_star) begin
                    state_nxt = S_SET_NEW;
                    buf_op    = BUF_CLEAR;
                end
            end
            S_SET_NEW: begin
                if (entry_exp) begin
                    state_nxt = S_IDLE;
                    buf_op    = BUF_CLEAR;
                end else if (is_digit) begin
                    buf_op    = BUF_SHIFT;
                    timer_clr = 1'b1;
                end else if (is_hash || is_star) begin
                    code_wr   = is_hash && full_ok;
                    state_nxt = S_IDLE;
                    buf_op    = BUF_CLEAR;
                end
            end
            S_LOCKOUT: begin
                if (lock_exp) begin
                    state_nxt = S_IDLE;
                    fail_nxt  = 3'd0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        lock    = !((state == S_OPEN) || (state == S_SET_NEW));
        green   = (state == S_OPEN) || (state == S_SET_NEW);
        blue    = (state == S_ENTRY) || (state == S_SET_NEW);
        lockout = (state == S_LOCKOUT);
    end

    // Digit buffer, stored code, failure counter and shared timer
    always_ff @(posedge clk) begin
        if (rst) begin
            code_reg <= DEFAULT_CODE;
            code_buf <= '0;
            dig_cnt  <= '0;
            overflow <= 1'b0;
            timer    <= '0;
            fail_cnt <= 3'd0;
        end else begin
            fail_cnt <= fail_nxt;
            if (code_wr) code_reg <= code_buf;
            case (buf_op)
                BUF_CLEAR: begin
                    code_buf <= '0;
                    dig_cnt  <= '0;
                    overflow <= 1'b0;
                end
                BUF_LOAD: begin
                    code_buf <= W'(key_code);
                    dig_cnt  <= CW'(1);
                    overflow <= 1'b0;
                end
                BUF_SHIFT: begin
                    code_buf <= buf_shifted[W-1:0];
                    if (dig_cnt == FULL_CNT) overflow <= 1'b1;
                    else                     dig_cnt  <= dig_cnt + CW'(1);
                end
                default: ;
            endcase
            // Expiry always forces a state change, so the timer never wraps
            if ((state_nxt != state) || timer_clr)
                timer <= '0;
            else if ((state != S_IDLE) && (state != S_CHECK))
                timer <= timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_safe_code_sequencer.sv
// Directed bench for safe_code_sequencer with short timer parameters.
module tb_safe_code_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       lock, green, blue, lockout;
    logic [2:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] K_STAR = 4'hA;
    localparam logic [3:0] K_HASH = 4'hB;

    safe_code_sequencer #(
        .CODE_LEN(4), .MAX_FAIL(3), .TIMEOUT_CYCLES(20),
        .UNLOCK_CYCLES(30), .LOCKOUT_CYCLES(50), .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .lock(lock), .green(green), .blue(blue), .lockout(lockout),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Key is held for one cycle; returns at the negedge after it was sampled
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // Presses n digits (most significant nibble first) then '#'; returns in CHECK
    task automatic enter_code(input logic [31:0] digits, input int n);
        logic [31:0] d;
        d = digits;
        for (int i = n - 1; i >= 0; i--) press(d[4*i +: 4]);
        press(K_HASH);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        wait_n(2);
        rst = 1'b0;
        check("rst_lock", 8'(lock), 8'd1);
        check("rst_green", 8'(green), 8'd0);
        check("rst_blue", 8'(blue), 8'd0);
        check("rst_lockout", 8'(lockout), 8'd0);
        check("rst_fail", 8'(fail_cnt), 8'd0);

        // Correct code opens, auto-relock after exactly 30 cycles
        press(4'h1);
        check("entry_blue", 8'(blue), 8'd1);
        press(4'h2); press(4'h3); press(4'h4); press(K_HASH);
        check("check_still_locked", 8'(lock), 8'd1);
        wait_n(1);
        check("open_lock", 8'(lock), 8'd0);
        check("open_green", 8'(green), 8'd1);
        check("open_blue", 8'(blue), 8'd0);
        check("open_fail", 8'(fail_cnt), 8'd0);
        press(4'h7);
        check("open_digit_ignored", 8'(lock), 8'd0);
        wait_n(28);
        check("open_last_cycle", 8'(lock), 8'd0);
        wait_n(1);
        check("relock_30", 8'(lock), 8'd1);
        check("relock_green", 8'(green), 8'd0);

        // Three wrong codes lead to lockout
        enter_code(32'h1235, 4); wait_n(1);
        check("wrong1_fail", 8'(fail_cnt), 8'd1);
        check("wrong1_lockout", 8'(lockout), 8'd0);
        enter_code(32'h1235, 4); wait_n(1);
        check("wrong2_fail", 8'(fail_cnt), 8'd2);
        enter_code(32'h1235, 4); wait_n(1);
        check("wrong3_lockout", 8'(lockout), 8'd1);
        check("wrong3_fail", 8'(fail_cnt), 8'd3);
        enter_code(32'h1234, 4);
        check("lockout_keys_ignored", 8'(lockout), 8'd1);
        check("lockout_still_locked", 8'(lock), 8'd1);
        check("lockout_fail_held", 8'(fail_cnt), 8'd3);
        wait_n(44);
        check("lockout_last_cycle", 8'(lockout), 8'd1);
        wait_n(1);
        check("lockout_end", 8'(lockout), 8'd0);
        check("lockout_end_fail", 8'(fail_cnt), 8'd0);

        // Overflow and short entries are rejected
        enter_code(32'h12345, 5); wait_n(1);
        check("overflow_fail", 8'(fail_cnt), 8'd1);
        check("overflow_lock", 8'(lock), 8'd1);
        enter_code(32'h123, 3); wait_n(1);
        check("short_fail", 8'(fail_cnt), 8'd2);
        check("short_lock", 8'(lock), 8'd1);
        press(4'h9); press(K_STAR);
        enter_code(32'h1234, 4); wait_n(1);
        check("star_clear_then_open", 8'(lock), 8'd0);
        check("open_clears_fail", 8'(fail_cnt), 8'd0);

        // Change code to 9876 while open
        press(K_STAR);
        check("setnew_green", 8'(green), 8'd1);
        check("setnew_blue", 8'(blue), 8'd1);
        check("setnew_lock", 8'(lock), 8'd0);
        enter_code(32'h9876, 4);
        check("setnew_relock", 8'(lock), 8'd1);
        check("setnew_blue_off", 8'(blue), 8'd0);
        enter_code(32'h1234, 4); wait_n(1);
        check("old_code_rejected", 8'(lock), 8'd1);
        check("old_code_fail", 8'(fail_cnt), 8'd1);
        enter_code(32'h9876, 4); wait_n(1);
        check("new_code_opens", 8'(lock), 8'd0);
        press(K_STAR);
        enter_code(32'h98, 2);
        check("short_setnew_relock", 8'(lock), 8'd1);
        enter_code(32'h0098, 4); wait_n(1);
        check("short_setnew_not_stored", 8'(lock), 8'd1);
        enter_code(32'h9876, 4); wait_n(1);
        check("code_kept_9876", 8'(lock), 8'd0);
        press(K_HASH);
        check("hash_relock", 8'(lock), 8'd1);

        // Entry timeout with fail_cnt at 1; key on the expiry cycle is dropped
        enter_code(32'h5555, 4); wait_n(1);
        check("pre_timeout_fail", 8'(fail_cnt), 8'd1);
        press(4'h1); press(4'h2);
        wait_n(19);
        check("timeout_last_cycle", 8'(blue), 8'd1);
        press(4'h3);
        check("timeout_idle_blue", 8'(blue), 8'd0);
        check("timeout_fail_kept", 8'(fail_cnt), 8'd1);
        wait_n(2);
        check("expiry_key_dropped", 8'(blue), 8'd0);

        // Reset while open restores default code
        enter_code(32'h9876, 4); wait_n(1);
        check("open_before_rst", 8'(lock), 8'd0);
        pulse_rst();
        check("rst_open_lock", 8'(lock), 8'd1);
        check("rst_open_fail", 8'(fail_cnt), 8'd0);
        enter_code(32'h9876, 4); wait_n(1);
        check("rst_code_9876_gone", 8'(lock), 8'd1);
        enter_code(32'h1234, 4); wait_n(1);
        check("rst_default_opens", 8'(lock), 8'd0);
        press(K_HASH);

        // Reset during lockout
        enter_code(32'h1111, 4); wait_n(1);
        enter_code(32'h1111, 4); wait_n(1);
        enter_code(32'h1111, 4); wait_n(1);
        check("second_lockout", 8'(lockout), 8'd1);
        pulse_rst();
        check("rst_lockout_clear", 8'(lockout), 8'd0);
        check("rst_lockout_fail", 8'(fail_cnt), 8'd0);
        check("rst_lockout_lock", 8'(lock), 8'd1);
        enter_code(32'h1234, 4); wait_n(1);
        check("after_rst_opens", 8'(lock), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
